req_ack_responder: RTL
======================

Name: req_ack_responder

Overview:
- Responder end of the four-phase req/ack handshake that the SVA benches drive and check.
- Samples `req` and captures `req_data`.
- Raises `ack` after a fixed, parameterised delay and presents a response word while `ack` is high.
- Drops `ack` once `req` is withdrawn, and flags requesters that drop `req` before `ack`.
- Serves as the DUT on the receiving side of req/ack property benches.

Parameters:
- DW, 8, width of `req_data` and `rsp_data`.
- ACK_DLY, 2, clock edges between the edge that first samples `req`=1 and the edge that raises `ack`. Legal range 0..15.
- CNT_W, 16, width of the transaction counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  request from initiator; level, four-phase.
- req_data  input  DW  request payload; valid while `req`=1.
- ack  output  1  acknowledge, registered.
- rsp_data  output  DW  response payload; valid while `ack`=1.
- busy  output  1  1 in any state other than IDLE.
- err  output  1  one-cycle pulse on protocol violation.
- txn_cnt  output  CNT_W  count of completed acknowledges.

Behaviour:
- Reset:
  - Clock: one clock, `clk`. Reset: `rst_n`, asynchronous assert, active-low.
  - While `rst_n`=0, all outputs are 0 immediately: `ack`, `rsp_data`, `busy`, `err`, `txn_cnt`. FSM is in IDLE and the delay counter is 0.
  - Reset asserted mid-transaction aborts it: `ack` drops without waiting for a clock, no `err`, `txn_cnt` is not incremented.
  - On release, the first active edge is treated as IDLE.
- FSM states: IDLE, WAIT, ACK, DRAIN.
- IDLE:
  - On the edge E0 sampling `req`=1: capture `req_data` into `cap`.
  - If ACK_DLY=0, go to ACK directly (`ack`=1 after E0).
  - Otherwise load `dcnt`=ACK_DLY and go to WAIT.
- WAIT:
  - Each edge with `req`=1 decrements `dcnt`.
  - The edge where `dcnt`=1 goes to ACK, so `ack` rises after edge E0+ACK_DLY.
  - If `req` is sampled 0 in WAIT: pulse `err` for one cycle, return to IDLE, no `ack`, counter unchanged.
- ACK:
  - `ack`=1.
  - `rsp_data` = (`cap` + 1) mod 2^DW, registered on entry and held stable for the whole ACK state.
  - `txn_cnt` increments by 1 on the entry edge and wraps from 2^CNT_W-1 to 0.
  - The edge sampling `req`=0 clears `ack` and goes to DRAIN.
  - `rsp_data` keeps its last value after `ack` falls; it is only updated on the next ACK entry.
- DRAIN: exactly one cycle, guaranteeing `ack` is low for at least one full cycle before the next `ack`, then IDLE.
- A new `req`=1 is sampled no earlier than the IDLE edge. If `req` is still high when IDLE is reached (initiator re-raised at once), a new transaction starts on that edge.
- `req_data` changes during WAIT/ACK are ignored; only the value at E0 is used.
- `busy`=1 in WAIT, ACK, DRAIN; 0 in IDLE.
- `err` and an ACK entry never coincide. `err` is 0 in every cycle not immediately following a WAIT abort.
- `req` is assumed synchronous to `clk`; no synchroniser inside.

Test Plan:
- Reset, then `req`=0 for 10 cycles -> `ack`=0, `busy`=0, `err`=0, `txn_cnt`=0, `rsp_data`=0 throughout.
- ACK_DLY=2: `req`=1 with `req_data`=8'h3C at edge 1, held until `ack`, then `req`=0 -> `ack` high after edge 3. `rsp_data`=8'h3D, `txn_cnt`=1. `ack` low one edge after `req` is sampled 0; `busy` clears one edge later.
- `req_data`=8'hFF, ACK_DLY=0 -> `ack` high after the first sampling edge, `rsp_data`=8'h00 (wrap).
- ACK_DLY=4: `req` held for 2 cycles then dropped -> `err` pulse of exactly 1 cycle, no `ack`, `txn_cnt` unchanged, `busy` returns to 0.
- Back-to-back: `req` re-raised the cycle after `ack` falls, 5 transactions -> `ack` low for at least 1 full cycle between each, `txn_cnt`=5. With CNT_W=2 preloaded by running 4 transactions, the 5th gives `txn_cnt`=1.
- `rst_n` pulsed low mid-ACK (between edges) -> `ack` and `busy` go 0 immediately and asynchronously, `txn_cnt`=0, `err`=0. The next `req` completes normally.

Source files
------------

// File: rtl/req_ack_responder.sv
`default_nettype none
// ============================================================================
// Module      : req_ack_responder
// Description : Responder side of a four-phase req/ack handshake. Captures
//               the request payload, raises ack after ACK_DLY clock edges,
//               returns payload+1 while ack is high, and flags an initiator
//               that withdraws req before it has been acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module req_ack_responder #(
  parameter int DW      = 8,
  parameter int ACK_DLY = 2,   // legal range 0..15
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [DW-1:0]    req_data,
  output logic             ack,
  output logic [DW-1:0]    rsp_data,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] txn_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACK   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [3:0] c_ACK_DLY  = 4'(ACK_DLY);
  localparam logic [3:0] c_DCNT_ONE = 4'd1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_dcnt;
  logic [3:0]       w_dcnt_nxt;
  logic [DW-1:0]    r_cap;
  logic [DW-1:0]    w_cap_nxt;
  logic [DW-1:0]    r_rsp;
  logic [DW-1:0]    w_rsp_src;
  logic             r_err;
  logic             w_err_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_ack_entry;

  // State register; reset aborts any transaction in flight without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode, delay countdown, payload capture and abort detection.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_cap_nxt   = r_cap;
    w_err_nxt   = 1'b0;
    w_ack_entry = 1'b0;
    w_rsp_src   = r_cap;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          // With zero delay the response is built from the live payload,
          // because the capture register is only written on this same edge.
          w_cap_nxt = req_data;
          w_rsp_src = req_data;
          if (ACK_DLY == 0) begin
            w_state_nxt = S_ACK;
            w_ack_entry = 1'b1;
          end else begin
            w_dcnt_nxt  = c_ACK_DLY;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          w_err_nxt   = 1'b1;
          w_dcnt_nxt  = 4'd0;
          w_state_nxt = S_IDLE;
        end else if (r_dcnt == c_DCNT_ONE) begin
          w_dcnt_nxt  = 4'd0;
          w_state_nxt = S_ACK;
          w_ack_entry = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt - c_DCNT_ONE;
        end
      end
      S_ACK: begin
        if (!req) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // One guaranteed low cycle on ack; req is not looked at here.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath registers: delay counter, capture, response, error pulse, count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dcnt <= 4'd0;
      r_cap  <= '0;
      r_rsp  <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_dcnt <= w_dcnt_nxt;
      r_cap  <= w_cap_nxt;
      r_err  <= w_err_nxt;
      if (w_ack_entry) begin
        r_rsp <= w_rsp_src + DW'(1);
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign ack      = (r_state == S_ACK);
  assign busy     = (r_state != S_IDLE);
  assign rsp_data = r_rsp;
  assign err      = r_err;
  assign txn_cnt  = r_cnt;

endmodule
`default_nettype wire
